// File: rtl/tt_vpu_ovi_pkg.sv
// Shared OVI load-drain types: default widths, drain FSM state encoding and
// the LQ data word type.
package tt_vpu_ovi_pkg;

    localparam int LQID_W_DEFAULT = 3;
    localparam int DATA_W_DEFAULT = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WB,
        DONE
    } drain_state_e;

    typedef logic [DATA_W_DEFAULT-1:0] lq_data_t;

endpackage

// File: rtl/tt_load_buffer_drain_if.sv
// Bundle of drain request, LQ RAM read port, writeback stream and free port.
// slave = drain responder, master = scoreboard / RAM / VRF writer side.
interface tt_load_buffer_drain_if
    import tt_vpu_ovi_pkg::*;
#(
    parameter int LQID_W = LQID_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    logic              i_drain_load_buffer;
    logic [LQID_W-1:0] i_drain_ref_count;
    logic [LQID_W-1:0] i_drain_lqid_start;
    logic              o_draining_load_buffer;
    logic              o_lq_rd_en;
    logic [LQID_W-1:0] o_lq_rd_id;
    logic [DATA_W-1:0] i_lq_rd_data;
    logic              o_wb_valid;
    logic              i_wb_ready;
    logic [DATA_W-1:0] o_wb_data;
    logic [LQID_W-1:0] o_wb_lqid;
    logic              o_wb_last;
    logic              o_lq_free;
    logic [LQID_W-1:0] o_lq_free_id;

    modport slave (
        input  i_drain_load_buffer, i_drain_ref_count, i_drain_lqid_start,
        input  i_lq_rd_data, i_wb_ready,
        output o_draining_load_buffer, o_lq_rd_en, o_lq_rd_id,
        output o_wb_valid, o_wb_data, o_wb_lqid, o_wb_last,
        output o_lq_free, o_lq_free_id
    );

    modport master (
        output i_drain_load_buffer, i_drain_ref_count, i_drain_lqid_start,
        output i_lq_rd_data, i_wb_ready,
        input  o_draining_load_buffer, o_lq_rd_en, o_lq_rd_id,
        input  o_wb_valid, o_wb_data, o_wb_lqid, o_wb_last,
        input  o_lq_free, o_lq_free_id
    );

endinterface

// File: rtl/tt_load_buffer_drain.sv
// Load-buffer drain responder: walks a wrapping range of LQ entries, reads each
// from the synchronous LQ RAM, streams it to the VRF writer and frees it.
module tt_load_buffer_drain
    import tt_vpu_ovi_pkg::*;
#(
    parameter int LQID_W = LQID_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input logic                   clk,
    input logic                   reset,
    tt_load_buffer_drain_if.slave bus
);

    drain_state_e      state_q, state_d;
    logic [LQID_W-1:0] cur_id_q, cur_id_d;
    logic [LQID_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              busy_q, busy_d;
    logic              rd_en_q, rd_en_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_last_q, wb_last_d;
    logic              wb_hs;

    assign wb_hs = wb_valid_q & bus.i_wb_ready;

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        remaining_d = remaining_q;
        wb_data_d   = wb_data_q;
        case (state_q)
            IDLE: begin
                if (bus.i_drain_load_buffer) begin
                    cur_id_d    = bus.i_drain_lqid_start;
                    remaining_d = bus.i_drain_ref_count;
                    state_d     = (bus.i_drain_ref_count != '0) ? RD : DONE;
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                wb_data_d = bus.i_lq_rd_data;
                state_d   = WB;
            end
            WB: begin
                if (wb_hs) begin
                    // Natural wrap of the id at the LQ depth.
                    cur_id_d    = cur_id_q + LQID_W'(1);
                    remaining_d = remaining_q - LQID_W'(1);
                    state_d     = (remaining_q == LQID_W'(1)) ? DONE : RD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d     = (state_d != IDLE);
        rd_en_d    = (state_d == RD);
        wb_valid_d = (state_d == WB);
        wb_last_d  = (state_d == WB) && (remaining_d == LQID_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_id_q    <= '0;
            remaining_q <= '0;
            wb_data_q   <= '0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            remaining_q <= remaining_d;
            wb_data_q   <= wb_data_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            wb_valid_q  <= wb_valid_d;
            wb_last_q   <= wb_last_d;
        end
    end

    assign bus.o_draining_load_buffer = busy_q;
    assign bus.o_lq_rd_en             = rd_en_q;
    assign bus.o_lq_rd_id             = cur_id_q;
    assign bus.o_wb_valid             = wb_valid_q;
    assign bus.o_wb_data              = wb_data_q;
    assign bus.o_wb_lqid              = cur_id_q;
    assign bus.o_wb_last              = wb_last_q;
    // The free pulse is the writeback handshake itself.
    assign bus.o_lq_free              = wb_hs;
    assign bus.o_lq_free_id           = cur_id_q;

endmodule

// File: tb/tb_tt_load_buffer_drain.sv
// Bench for tt_load_buffer_drain: table-driven and random drains checked against
// a queue-based model of which entries must be read, streamed and freed.
module tb_tt_load_buffer_drain;
    import tt_vpu_ovi_pkg::*;

    localparam int LW    = LQID_W_DEFAULT;
    localparam int DEPTH = 1 << LW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tt_load_buffer_drain_if #(.LQID_W(LW), .DATA_W(DATA_W_DEFAULT)) bus ();

    tt_load_buffer_drain #(.LQID_W(LW), .DATA_W(DATA_W_DEFAULT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int       id;
        lq_data_t data;
        bit       last;
    } beat_t;

    typedef struct {
        int start;
        int count;
        int rmode;
        int exp_busy;
        int exp_last_id;
    } vec_t;

    int       tests = 0;
    int       fails = 0;
    lq_data_t mem [DEPTH];
    int       rd_q[$];
    beat_t    beat_q[$];
    int       free_q[$];
    int       busy_cycles = 0;
    int       stall_cycles = 0;
    int       viol = 0;
    int       ready_mode = 0;   // 0: always ready, 1: random, 2: man_ready
    logic     man_ready = 1'b1;
    logic     pv = 1'b0, pr = 1'b0, pl = 1'b0;
    lq_data_t pd = '0;
    logic [LW-1:0] pid = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Synchronous LQ RAM: data returns the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.o_lq_rd_en) bus.i_lq_rd_data <= mem[bus.o_lq_rd_id];
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      bus.i_wb_ready = 1'b1;
        else if (ready_mode == 1) bus.i_wb_ready = 1'($urandom_range(0, 1));
        else                      bus.i_wb_ready = man_ready;
    end

    // Observation at the falling edge: record reads, beats and frees; count
    // protocol violations (exclusivity, free tied to handshake, stable stalls).
    always @(negedge clk) begin
        if (reset) begin
            pv <= 1'b0;
        end else begin
            if (bus.o_draining_load_buffer) busy_cycles <= busy_cycles + 1;
            if (bus.o_lq_rd_en) rd_q.push_back(int'(bus.o_lq_rd_id));
            if (bus.o_lq_rd_en && bus.o_wb_valid) viol <= viol + 1;
            if (bus.o_wb_valid && !bus.i_wb_ready) stall_cycles <= stall_cycles + 1;
            if (bus.o_wb_valid && bus.i_wb_ready) begin
                beat_q.push_back('{int'(bus.o_wb_lqid), bus.o_wb_data, bus.o_wb_last});
                if (!bus.o_lq_free || bus.o_lq_free_id != bus.o_wb_lqid) viol <= viol + 1;
            end else if (bus.o_lq_free) begin
                viol <= viol + 1;
            end
            if (bus.o_lq_free) free_q.push_back(int'(bus.o_lq_free_id));
            if (pv && !pr && (!bus.o_wb_valid || bus.o_wb_data !== pd ||
                              bus.o_wb_lqid !== pid || bus.o_wb_last !== pl))
                viol <= viol + 1;
            pv  <= bus.o_wb_valid;
            pr  <= bus.i_wb_ready;
            pd  <= bus.o_wb_data;
            pid <= bus.o_wb_lqid;
            pl  <= bus.o_wb_last;
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.o_draining_load_buffer && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.o_draining_load_buffer) check({name, "_idle_timeout"}, 1, 0);
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        ready_mode = m;
    endtask

    // One complete drain, compared entry by entry against the model:
    // entry k of the drain is lqid (start+k) mod DEPTH, carrying mem[that id].
    task automatic run_drain(input int start, input int count, input int exp_busy,
                             input int exp_last, input string name);
        int rb, bb, fb, bc, sc, vb, eb, id;
        @(posedge clk); #1;
        wait_idle(name);
        rb = rd_q.size(); bb = beat_q.size(); fb = free_q.size();
        bc = busy_cycles; sc = stall_cycles; vb = viol;
        bus.i_drain_lqid_start  = LW'(start);
        bus.i_drain_ref_count   = LW'(count);
        bus.i_drain_load_buffer = 1'b1;
        @(posedge clk); #1;
        bus.i_drain_load_buffer = 1'b0;
        check({name, "_accept_busy"}, 64'(bus.o_draining_load_buffer), 1);
        wait_idle(name);
        check({name, "_nreads"}, rd_q.size() - rb, count);
        check({name, "_nbeats"}, beat_q.size() - bb, count);
        check({name, "_nfrees"}, free_q.size() - fb, count);
        for (int k = 0; k < count; k++) begin
            id = (start + k) % DEPTH;
            if (rb + k < rd_q.size())   check({name, "_rd_id"}, rd_q[rb + k], id);
            if (fb + k < free_q.size()) check({name, "_free_id"}, free_q[fb + k], id);
            if (bb + k < beat_q.size()) begin
                check({name, "_wb_lqid"}, beat_q[bb + k].id, id);
                check({name, "_wb_data"}, beat_q[bb + k].data, mem[id]);
                check({name, "_wb_last"}, 64'(beat_q[bb + k].last), 64'(k == count - 1));
            end
        end
        if (count > 0 && beat_q.size() > 0)
            check({name, "_last_lqid"}, beat_q[beat_q.size() - 1].id, exp_last);
        eb = (exp_busy >= 0) ? exp_busy : 3 * count + 1 + (stall_cycles - sc);
        check({name, "_busy_cycles"}, busy_cycles - bc, eb);
        check({name, "_protocol"}, viol - vb, 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.o_wb_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_wb_valid) check({name, "_valid_timeout"}, 1, 0);
    endtask

    vec_t vecs [6];

    initial begin
        int fb, s, c, m, bb;
        vecs = '{'{2, 3, 0, 10, 4}, '{6, 3, 0, 10, 0}, '{0, 0, 0, 1, 0},
                 '{7, 7, 0, 22, 5}, '{5, 1, 0, 4, 5},  '{1, 4, 1, -1, 4}};
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};

        reset = 1'b1;
        bus.i_drain_load_buffer = 1'b0;
        bus.i_drain_ref_count   = '0;
        bus.i_drain_lqid_start  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {bus.o_draining_load_buffer, bus.o_lq_rd_en, bus.o_wb_valid,
                             bus.o_wb_last, bus.o_lq_free}, 0);
        check("reset_data", {bus.o_wb_data}, 0);
        check("reset_ids", {bus.o_lq_rd_id, bus.o_wb_lqid, bus.o_lq_free_id}, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            set_mode(vecs[i].rmode);
            run_drain(vecs[i].start, vecs[i].count, vecs[i].exp_busy,
                      vecs[i].exp_last_id, $sformatf("vec%0d", i));
        end

        // Backpressure: beat must hold still and no free until ready rises.
        @(negedge clk);
        mem[3] = 64'hDEAD;
        ready_mode = 2;
        man_ready = 1'b0;
        @(posedge clk); #1;
        wait_idle("bp");
        bus.i_drain_lqid_start = 3'd3; bus.i_drain_ref_count = 3'd1;
        bus.i_drain_load_buffer = 1'b1;
        @(posedge clk); #1;
        bus.i_drain_load_buffer = 1'b0;
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {bus.o_wb_valid, bus.o_lq_free, bus.o_wb_lqid}, {1'b1, 1'b0, 3'd3});
            check("bp_data", bus.o_wb_data, 64'hDEAD);
            if (i < 4) @(negedge clk);
        end
        man_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {bus.o_wb_valid, bus.o_lq_free, bus.o_lq_free_id, bus.o_wb_last},
              {1'b1, 1'b1, 3'd3, 1'b1});
        ready_mode = 0;

        // Request held high across a drain: re-evaluated on the first idle cycle.
        @(posedge clk); #1;
        wait_idle("held");
        bb = beat_q.size();
        bus.i_drain_lqid_start = 3'd0; bus.i_drain_ref_count = 3'd2;
        bus.i_drain_load_buffer = 1'b1;
        @(posedge clk); #1;
        bus.i_drain_lqid_start = 3'd1; bus.i_drain_ref_count = 3'd1;
        wait_idle("held_first");
        @(posedge clk); #1;
        check("held_second_accept", 64'(bus.o_draining_load_buffer), 1);
        bus.i_drain_load_buffer = 1'b0;
        wait_idle("held_second");
        check("held_nbeats", beat_q.size() - bb, 3);
        if (beat_q.size() > 0) begin
            check("held_last_id", beat_q[beat_q.size() - 1].id, 1);
            check("held_last_flag", 64'(beat_q[beat_q.size() - 1].last), 1);
        end

        // Asynchronous reset while a beat is stalled in writeback.
        @(negedge clk);
        ready_mode = 2;
        man_ready = 1'b0;
        @(posedge clk); #1;
        bus.i_drain_lqid_start = 3'd4; bus.i_drain_ref_count = 3'd2;
        bus.i_drain_load_buffer = 1'b1;
        @(posedge clk); #1;
        bus.i_drain_load_buffer = 1'b0;
        wait_valid("rst");
        fb = free_q.size();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("rst_mid_ctrl", {bus.o_draining_load_buffer, bus.o_lq_rd_en, bus.o_wb_valid,
                               bus.o_wb_last, bus.o_lq_free}, 0);
        check("rst_mid_data", bus.o_wb_data, 0);
        check("rst_mid_ids", {bus.o_lq_rd_id, bus.o_wb_lqid, bus.o_lq_free_id}, 0);
        @(negedge clk);
        ready_mode = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_no_free", free_q.size() - fb, 0);
        run_drain(3, 2, 7, 4, "post_rst");

        // Random drains, random backpressure.
        for (int i = 0; i < 10; i++) begin
            s = int'($urandom_range(0, DEPTH - 1));
            c = int'($urandom_range(0, DEPTH - 1));
            m = int'($urandom_range(0, 1));
            set_mode(m);
            run_drain(s, c, -1, (s + c - 1 + DEPTH) % DEPTH, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
